fixed_divider: RTL and testbench
================================

FIXED_DIVIDER -- requirements
Module: fixed_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the operand and result width in bits (signed two's complement).
REQ-002 The block SHALL have parameter FRAC, default 8, meaning the number of fractional bits (default format Q8.8).
REQ-003 Port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port start  input  1  request a division; sampled only in IDLE.
REQ-006 Port dividend  input  WIDTH  signed fixed-point numerator; captured on the start edge.
REQ-007 Port divisor  input  WIDTH  signed fixed-point denominator; captured on the start edge.
REQ-008 Port quotient  output  WIDTH  signed fixed-point result; registered, held until the next result.
REQ-009 Port busy  output  1  high while a division is in progress.
REQ-010 Port done  output  1  one-cycle pulse; quotient and flags are valid from this cycle.
REQ-011 Port ovf  output  1  result saturated; valid with done, held with quotient.
REQ-012 Port div_by_zero  output  1  divisor was zero; valid with done, held with quotient.

Function
REQ-013 The state machine SHALL have states IDLE, CALC and FINISH.
- IDLE->CALC: start=1 and divisor!=0.
- IDLE->FINISH: start=1 and divisor==0.
- CALC->FINISH: after K iterations.
- FINISH->IDLE: always, after one cycle.
REQ-014 The capture edge SHALL register the operand signs, their magnitudes (WIDTH+1 bits, so that the most negative value is exact) and result sign = sign(dividend) XOR sign(divisor); busy SHALL go high at this edge.
REQ-015 CALC SHALL perform unsigned restoring division of |dividend|<<FRAC by |divisor|, one quotient bit per cycle, K cycles.
- K = WIDTH+FRAC+1 with rounding (REQ-026), or WIDTH+FRAC without.
REQ-016 The FINISH edge SHALL register quotient and flags, deassert busy and assert done for exactly one cycle.
- Normal latency: done high K+1 edges after the capture edge.
- Divide-by-zero latency: 1 edge.
REQ-017 Sign and saturation rules:
- The magnitude is negated when the result sign is negative.
- Positive magnitude > 2^(WIDTH-1)-1 SHALL give 0x7FFF with ovf=1.
- Negative magnitude > 2^(WIDTH-1) SHALL give 0x8000 with ovf=1.
- Otherwise ovf=0.
REQ-018 Divisor==0 SHALL give div_by_zero=1 and ovf=0.
- Quotient = 0x7FFF if dividend>=0, else 0x8000.
REQ-019 start while busy=1 SHALL be ignored, with no effect on the division in progress.
REQ-020 start asserted in the cycle where done=1 SHALL be accepted, since the state is IDLE; back-to-back throughput is one result per K+2 cycles.
REQ-021 Operand inputs SHALL be don't-care outside the start edge; the result depends only on captured values.
REQ-022 A zero dividend with a nonzero divisor SHALL give quotient 0, with no negative zero and ovf=0.

Reset
REQ-023 rst=1 at a clock edge SHALL force state=IDLE, quotient=0, busy=0, done=0, ovf=0 and div_by_zero=0.
REQ-024 rst SHALL take priority over start and over any CALC or FINISH activity.
- Reset mid-division aborts the division with no done pulse.
REQ-025 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-026 Macro FIXED_DIVIDER_ROUND_EN SHALL select the rounding mode.
- Defined: one extra quotient bit is computed (K=WIDTH+FRAC+1) and the magnitude is rounded half away from zero before sign and saturation.
- Undefined: no extra bit (K=WIDTH+FRAC) and the magnitude is truncated toward zero.

Verification
REQ-027 dividend=0x0300 (3.0), divisor=0x0200 (2.0), start for 1 cycle -> quotient=0x0180 (1.5), ovf=0, done pulse after 26 edges (ROUND_EN defined) or 25 (undefined).
REQ-028 dividend=0x0200, divisor=0x0300 -> quotient=0x00AB with ROUND_EN defined, 0x00AA with it undefined; dividend=0x0100, divisor=0x0300 -> 0x0055 in both modes.
REQ-029 dividend=0xFD00 (-3.0), divisor=0x0200 -> quotient=0xFE80 (-1.5); dividend=0xFD00, divisor=0xFE00 -> quotient=0x0180.
REQ-030 dividend=0x7F00, divisor=0x0080 -> quotient=0x7FFF, ovf=1; dividend=0x8000, divisor=0x0080 -> quotient=0x8000, ovf=1.
REQ-031 dividend=0x0100, divisor=0x0000 -> done one edge later, quotient=0x7FFF, div_by_zero=1; dividend=0xFF00, divisor=0x0000 -> quotient=0x8000, div_by_zero=1.
REQ-032 Reset and start-while-busy checks:
- rst for 1 cycle 10 cycles into CALC -> busy=0, done=0, quotient=0 next edge, and no done pulse follows.
- start pulsed during CALC -> ignored; only one done pulse, with the first result.

Source files
------------

// File: rtl/fixed_divider.sv
// Signed fixed-point restoring divider: one quotient bit per cycle, saturating result.
// Define FIXED_DIVIDER_ROUND_EN for round-half-away-from-zero; otherwise truncate toward zero.
module fixed_divider #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             div_by_zero
);

`ifdef FIXED_DIVIDER_ROUND_EN
  localparam int K = WIDTH + FRAC + 1;
`else
  localparam int K = WIDTH + FRAC;
`endif
  localparam int CW = $clog2(K);
  localparam logic [K:0] POS_MAX = {{(K-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [K:0] NEG_MAX = POS_MAX + 1'b1;

  // state  | meaning
  // IDLE   | waiting for start; operands captured on the start edge
  // CALC   | K restoring-division iterations
  // FINISH | register result and flags, pulse done
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t r_state, w_state_nxt;

  logic [WIDTH:0]   w_dvd_ext, w_dvs_ext, w_dvd_mag, w_dvs_mag;
  logic [WIDTH:0]   r_dvs_mag, w_trial;
  logic [WIDTH-1:0] r_rem, w_diff, w_res;
  logic [K-1:0]     w_num, r_num, r_quo;
  logic [K:0]       w_mag;
  logic [CW-1:0]    r_cnt;
  logic             r_neg, r_dvd_neg, r_dz;
  logic             w_dvs_zero, w_qbit, w_ovf;

  assign w_dvd_ext  = {dividend[WIDTH-1], dividend};
  assign w_dvs_ext  = {divisor[WIDTH-1], divisor};
  assign w_dvd_mag  = w_dvd_ext[WIDTH] ? (~w_dvd_ext + 1'b1) : w_dvd_ext;
  assign w_dvs_mag  = w_dvs_ext[WIDTH] ? (~w_dvs_ext + 1'b1) : w_dvs_ext;
  assign w_dvs_zero = (divisor == '0);

`ifdef FIXED_DIVIDER_ROUND_EN
  assign w_num = {w_dvd_mag[WIDTH-1:0], {FRAC{1'b0}}, 1'b0};
  // extra LSB is the half bit: (q + 1) >> 1 written as (q >> 1) + q[0]
  assign w_mag = {2'b00, r_quo[K-1:1]} + {{K{1'b0}}, r_quo[0]};
`else
  assign w_num = {w_dvd_mag[WIDTH-1:0], {FRAC{1'b0}}};
  assign w_mag = {1'b0, r_quo};
`endif

  // the magnitude's top bit sits just above the numerator MSB, so it seeds the remainder
  assign w_trial = {r_rem, r_num[K-1]};
  assign w_qbit  = (w_trial >= r_dvs_mag);
  assign w_diff  = w_trial[WIDTH-1:0] - r_dvs_mag[WIDTH-1:0];

  always_comb begin
    w_ovf = 1'b0;
    w_res = w_mag[WIDTH-1:0];
    if (r_neg) begin
      if (w_mag > NEG_MAX) begin
        w_ovf = 1'b1;
        w_res = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        w_res = ~w_mag[WIDTH-1:0] + 1'b1;
      end
    end else if (w_mag > POS_MAX) begin
      w_ovf = 1'b1;
      w_res = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = w_dvs_zero ? FINISH : CALC;
      CALC:    if (r_cnt == '0) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      div_by_zero <= 1'b0;
      r_neg       <= 1'b0;
      r_dvd_neg   <= 1'b0;
      r_dz        <= 1'b0;
      r_dvs_mag   <= '0;
      r_num       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_neg     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          r_dvd_neg <= dividend[WIDTH-1];
          r_dz      <= w_dvs_zero;
          r_dvs_mag <= w_dvs_mag;
          r_num     <= w_num;
          r_rem     <= {{(WIDTH-1){1'b0}}, w_dvd_mag[WIDTH]};
          r_quo     <= '0;
          r_cnt     <= CW'(K-1);
          busy      <= 1'b1;
        end
        CALC: begin
          r_num <= r_num << 1;
          r_rem <= w_qbit ? w_diff : w_trial[WIDTH-1:0];
          r_quo <= {r_quo[K-2:0], w_qbit};
          r_cnt <= r_cnt - 1'b1;
        end
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (r_dz) begin
            quotient    <= r_dvd_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            ovf         <= 1'b0;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= w_res;
            ovf         <= w_ovf;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_divider.sv
// Directed bench for fixed_divider (Q8.8); expected values follow FIXED_DIVIDER_ROUND_EN.
module tb_fixed_divider;
  localparam int W = 16;
  localparam int F = 8;
`ifdef FIXED_DIVIDER_ROUND_EN
  localparam int K = W + F + 1;
  localparam logic [15:0] Q_2_3  = 16'h00AB;
  localparam logic [15:0] Q_M2_3 = 16'hFF55;
`else
  localparam int K = W + F;
  localparam logic [15:0] Q_2_3  = 16'h00AA;
  localparam logic [15:0] Q_M2_3 = 16'hFF56;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient;
  logic        busy, done, ovf, div_by_zero;

  fixed_divider #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .busy(busy), .done(done), .ovf(ovf), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive start for one edge; operands are scrambled afterwards since they are don't-care
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    chk("busy_at_capture", busy, 1);
  endtask

  task automatic wait_result(input string tag, input logic [15:0] eq, input logic eo,
                             input logic ez, input int lat);
    int n = 0;
    logic got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1'b1;
    end
    chk({tag, "_done"}, got, 1);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_dz"}, div_by_zero, ez);
    chk({tag, "_busy"}, busy, 0);
  endtask

  typedef struct {
    string       tag;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        o;
    logic        z;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int dc;
    logic [15:0] q_seen;

    vecs.push_back('{"3_div_2",      16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0});
    vecs.push_back('{"2_div_3",      16'h0200, 16'h0300, Q_2_3,    1'b0, 1'b0});
    vecs.push_back('{"1_div_3",      16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0});
    vecs.push_back('{"m3_div_2",     16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0});
    vecs.push_back('{"m3_div_m2",    16'hFD00, 16'hFE00, 16'h0180, 1'b0, 1'b0});
    vecs.push_back('{"m2_div_3",     16'hFE00, 16'h0300, Q_M2_3,   1'b0, 1'b0});
    vecs.push_back('{"pos_sat",      16'h7F00, 16'h0080, 16'h7FFF, 1'b1, 1'b0});
    vecs.push_back('{"neg_sat",      16'h8000, 16'h0080, 16'h8000, 1'b1, 1'b0});
    vecs.push_back('{"neg_exact",    16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0});
    vecs.push_back('{"min_div_m1",   16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0});
    vecs.push_back('{"max_div_1",    16'h7FFF, 16'h0100, 16'h7FFF, 1'b0, 1'b0});
    vecs.push_back('{"dz_pos",       16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1});
    vecs.push_back('{"dz_neg",       16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{"zero_div_3",   16'h0000, 16'h0300, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{"zero_div_m3",  16'h0000, 16'hFD00, 16'h0000, 1'b0, 1'b0});

    // reset holds priority over a pending start
    dividend = 16'h0300;
    divisor  = 16'h0200;
    start    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dz", div_by_zero, 0);
    start = 1'b0;
    rst   = 1'b0;

    // each launch happens in the done cycle of the previous one (back-to-back)
    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b);
      wait_result(vecs[i].tag, vecs[i].q, vecs[i].o, vecs[i].z, vecs[i].z ? 1 : K + 1);
    end

    // reset 10 cycles into CALC aborts without a done pulse
    launch(16'h0300, 16'h0200);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_ovf", ovf, 0);
    dc = 0;
    repeat (K + 5) begin
      @(posedge clk); #1;
      if (done) dc++;
    end
    chk("abort_no_done", dc, 0);

    launch(16'h0300, 16'h0200);
    wait_result("post_rst", 16'h0180, 1'b0, 1'b0, K + 1);

    // start during CALC is ignored; exactly one single-cycle done with the first result
    @(posedge clk); #1;
    launch(16'h0300, 16'h0200);
    repeat (5) @(posedge clk);
    #1;
    dividend = 16'h0100;
    divisor  = 16'h0300;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dc = 0;
    q_seen = '0;
    repeat (K + 10) begin
      @(posedge clk); #1;
      if (done) begin
        dc++;
        q_seen = quotient;
      end
    end
    chk("busy_start_done_cnt", dc, 1);
    chk("busy_start_q", q_seen, 16'h0180);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
